// File: rtl/sdram_read_buffer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_read_buffer
// Description : Captures SDRAM read-burst words into an on-chip FIFO and
//               presents them to the consumer over a valid/ready handshake.
//               Emits single-cycle pause/unpause pulses around high/low
//               watermarks and keeps sticky overflow / protocol-error flags.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_read_buffer #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 64,
    parameter int BURST_LEN = 2,
    parameter int HI_WM     = 56,
    parameter int LO_WM     = 16
) (
    input  logic                   ck143,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   burst_start,
    input  logic [DATA_W-1:0]      rd_dq,
    output logic                   pause,
    output logic                   unpause,
    output logic [DATA_W-1:0]      out_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   overflow,
    output logic                   protocol_err
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_lw = c_aw + 1;
    localparam int c_cw = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    localparam logic [c_lw-1:0] c_depth = c_lw'(DEPTH);
    localparam logic [c_lw-1:0] c_hi_wm = c_lw'(HI_WM);
    localparam logic [c_lw-1:0] c_lo_wm = c_lw'(LO_WM);
    localparam logic [c_cw-1:0] c_last  = c_cw'(BURST_LEN - 1);

    localparam logic [0:0] c_idle    = 1'b0;
    localparam logic [0:0] c_capture = 1'b1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]   r_wr_ptr;
    logic [c_aw-1:0]   r_rd_ptr;
    logic [c_lw-1:0]   r_level;
    logic              r_throttle;
    logic [0:0]        r_state;
    logic [c_cw-1:0]   r_cnt;

    logic              w_flush;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_push_ok;
    logic              w_drop;
    logic [c_lw-1:0]   w_level_nxt;
    logic [c_lw-1:0]   w_level_avail;
    logic [c_aw-1:0]   w_rd_ptr_nxt;

    // Push/pop qualification and next-state occupancy.
    always_comb begin
        w_flush       = reset | clear;
        w_push        = ((r_state == c_idle) && burst_start) || (r_state == c_capture);
        w_pop         = out_valid & out_ready;
        w_full        = (r_level == c_depth);
        w_push_ok     = w_push && (!w_full || w_pop);
        w_drop        = w_push && w_full && !w_pop;
        w_level_nxt   = r_level + c_lw'(w_push_ok) - c_lw'(w_pop);
        // Words already resident before this edge's write; the head is only
        // reloaded from these so a fresh push takes one extra cycle to show.
        w_level_avail = r_level - c_lw'(w_pop);
        w_rd_ptr_nxt  = r_rd_ptr + c_aw'(w_pop);
    end

    assign level = r_level;

    // FIFO storage write; an aborted burst word never lands in memory.
    always_ff @(posedge ck143) begin
        if (w_push_ok && !w_flush) begin
            r_mem[r_wr_ptr] <= rd_dq;
        end
    end

    // Pointers, occupancy, registered head word and overflow flag.
    always_ff @(posedge ck143) begin
        if (w_flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            overflow  <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + c_aw'(1);
            end
            r_rd_ptr  <= w_rd_ptr_nxt;
            r_level   <= w_level_nxt;
            out_valid <= (w_level_avail != '0);
            if (w_level_avail != '0) begin
                out_data <= r_mem[w_rd_ptr_nxt];
            end
            if (w_drop) begin
                overflow <= 1'b1;
            end
        end
    end

    // Watermark throttle: one pause on crossing high, one unpause on crossing low.
    always_ff @(posedge ck143) begin
        if (w_flush) begin
            pause      <= 1'b0;
            // A flush while throttled must release the controller.
            unpause    <= !reset && r_throttle;
            r_throttle <= 1'b0;
        end else begin
            pause   <= 1'b0;
            unpause <= 1'b0;
            if ((w_level_nxt >= c_hi_wm) && !r_throttle) begin
                pause      <= 1'b1;
                r_throttle <= 1'b1;
            end else if ((w_level_nxt <= c_lo_wm) && r_throttle) begin
                unpause    <= 1'b1;
                r_throttle <= 1'b0;
            end
        end
    end

    // Burst capture FSM with word counter and protocol-error detection.
    always_ff @(posedge ck143) begin
        if (w_flush) begin
            r_state      <= c_idle;
            r_cnt        <= '0;
            protocol_err <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (burst_start && (BURST_LEN > 1)) begin
                        r_state <= c_capture;
                        r_cnt   <= c_cw'(1);
                    end
                end
                c_capture: begin
                    if (burst_start) begin
                        protocol_err <= 1'b1;
                    end
                    if (r_cnt == c_last) begin
                        r_state <= c_idle;
                        r_cnt   <= '0;
                    end else begin
                        r_cnt <= r_cnt + c_cw'(1);
                    end
                end
                default: begin
                    r_state <= c_idle;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sdram_read_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_read_buffer
// Description : Directed self-checking bench for sdram_read_buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_read_buffer;

    logic        ck143;
    logic        reset;
    logic        clear;
    logic        burst_start;
    logic [15:0] rd_dq;
    logic        pause;
    logic        unpause;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready;
    logic [6:0]  level;
    logic        overflow;
    logic        protocol_err;

    int          checks;
    int          errors;
    int          n_pause;
    int          n_unpause;
    int          n_both;
    logic [6:0]  lvl_pause;
    logic [6:0]  lvl_unpause;
    logic [15:0] got [$];

    sdram_read_buffer dut (
        .ck143        (ck143),
        .reset        (reset),
        .clear        (clear),
        .burst_start  (burst_start),
        .rd_dq        (rd_dq),
        .pause        (pause),
        .unpause      (unpause),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .level        (level),
        .overflow     (overflow),
        .protocol_err (protocol_err)
    );

    initial ck143 = 1'b0;
    always #5 ck143 = ~ck143;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: record the word accepted at this edge, then observe pulses.
    task automatic tick();
        if (out_valid && out_ready) got.push_back(out_data);
        @(posedge ck143);
        #1;
        if (pause) begin n_pause++; lvl_pause = level; end
        if (unpause) begin n_unpause++; lvl_unpause = level; end
        if (pause && unpause) n_both++;
    endtask

    task automatic burst(input logic [15:0] a, input logic [15:0] b);
        burst_start = 1'b1;
        rd_dq       = a;
        tick();
        burst_start = 1'b0;
        rd_dq       = b;
        tick();
        rd_dq       = 16'h0000;
    endtask

    task automatic drain();
        int t;
        t = 0;
        out_ready = 1'b1;
        while ((level != 7'd0 || out_valid) && t < 400) begin
            tick();
            t++;
        end
        check("drain_timeout", 32'(t < 400), 32'd1);
    endtask

    initial begin
        checks = 0; errors = 0; n_pause = 0; n_unpause = 0; n_both = 0;
        lvl_pause = '0; lvl_unpause = '0;
        reset = 1'b1; clear = 1'b0; burst_start = 1'b0; rd_dq = '0; out_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;

        // Reset state
        check("rst_level", 32'(level), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_pause", 32'(pause), 32'd0);
        check("rst_unpause", 32'(unpause), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_protocol_err", 32'(protocol_err), 32'd0);
        check("rst_no_pulses", 32'(n_pause + n_unpause), 32'd0);

        // Three bursts streaming with out_ready high
        out_ready = 1'b1;
        got.delete();
        burst_start = 1'b1; rd_dq = 16'h1111;
        tick();
        check("first_valid_edge0", 32'(out_valid), 32'd0);
        burst_start = 1'b0; rd_dq = 16'h2222;
        tick();
        check("first_valid_edge1", 32'(out_valid), 32'd1);
        check("first_data", 32'(out_data), 32'h1111);
        burst(16'h3333, 16'h4444);
        burst(16'h5555, 16'h6666);
        for (int i = 0; i < 6; i++) tick();
        check("stream_level", 32'(level), 32'd0);
        check("stream_count", 32'(got.size()), 32'd6);
        for (int i = 0; i < 6 && i < got.size(); i++)
            check("stream_word", 32'(got[i]), 32'(16'h1111 * (i + 1)));

        // Fill to the high watermark with out_ready low
        out_ready = 1'b0;
        n_pause = 0; n_unpause = 0;
        for (int k = 0; k < 28; k++)
            burst(16'hA000 + 16'(2 * k), 16'hA000 + 16'(2 * k + 1));
        check("fill_pause_count", 32'(n_pause), 32'd1);
        check("fill_pause_level", 32'(lvl_pause), 32'd56);
        check("fill_pause_now", 32'(pause), 32'd1);
        check("fill_level", 32'(level), 32'd56);
        check("fill_overflow", 32'(overflow), 32'd0);
        check("fill_head_stable", 32'(out_data), 32'hA000);

        // Drain: one unpause at level 16, nothing else
        got.delete();
        drain();
        for (int i = 0; i < 4; i++) tick();
        check("drain_unpause_count", 32'(n_unpause), 32'd1);
        check("drain_unpause_level", 32'(lvl_unpause), 32'd16);
        check("drain_pause_count", 32'(n_pause), 32'd1);
        check("drain_count", 32'(got.size()), 32'd56);
        for (int i = 0; i < 56 && i < got.size(); i++)
            check("drain_word", 32'(got[i]), 32'(16'hA000 + 16'(i)));

        // Overfill: 33 bursts ignoring pause
        out_ready = 1'b0;
        n_pause = 0; n_unpause = 0;
        for (int k = 0; k < 32; k++)
            burst(16'hC000 + 16'(2 * k), 16'hC000 + 16'(2 * k + 1));
        check("full_level", 32'(level), 32'd64);
        check("full_no_overflow", 32'(overflow), 32'd0);
        check("full_pause_count", 32'(n_pause), 32'd1);
        burst_start = 1'b1; rd_dq = 16'hC040;
        tick();
        burst_start = 1'b0;
        check("ovf_after_65", 32'(overflow), 32'd1);
        check("ovf_level_65", 32'(level), 32'd64);
        rd_dq = 16'hC041;
        tick();
        rd_dq = 16'h0000;
        check("ovf_level_66", 32'(level), 32'd64);
        got.delete();
        drain();
        check("ovf_drain_count", 32'(got.size()), 32'd64);
        for (int i = 0; i < 64 && i < got.size(); i++)
            check("ovf_drain_word", 32'(got[i]), 32'(16'hC000 + 16'(i)));
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Clear, then back-to-back burst_start
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr_overflow", 32'(overflow), 32'd0);
        check("clr_unpause_unthrottled", 32'(unpause), 32'd0);
        out_ready = 1'b0;
        burst_start = 1'b1; rd_dq = 16'hB001;
        tick();
        burst_start = 1'b1; rd_dq = 16'hB002;
        tick();
        burst_start = 1'b0; rd_dq = 16'hB003;
        tick();
        tick();
        check("perr_flag", 32'(protocol_err), 32'd1);
        check("perr_level", 32'(level), 32'd2);

        // Clear mid-burst while throttled
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr2_perr", 32'(protocol_err), 32'd0);
        n_pause = 0; n_unpause = 0;
        for (int k = 0; k < 28; k++)
            burst(16'hE000 + 16'(2 * k), 16'hE000 + 16'(2 * k + 1));
        check("abort_pause_count", 32'(n_pause), 32'd1);
        burst_start = 1'b1; rd_dq = 16'hD000;
        tick();
        burst_start = 1'b0; rd_dq = 16'hD001; clear = 1'b1;
        tick();
        clear = 1'b0; rd_dq = 16'h0000;
        check("abort_level", 32'(level), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_unpause", 32'(unpause), 32'd1);
        tick();
        tick();
        check("abort_unpause_once", 32'(n_unpause), 32'd1);
        check("abort_level_after", 32'(level), 32'd0);
        check("abort_valid_after", 32'(out_valid), 32'd0);
        check("no_simultaneous_pulses", 32'(n_both), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_read_buffer.md
Name: sdram_read_buffer

Overview:
- Downstream stage of the SDRAM read controller: captures read-burst words from the SDRAM data bus into an on-chip FIFO and hands them to the pixel/consumer side over a valid/ready handshake.
- Generates single-cycle pause/unpause pulses back to the controller so reads stop before the FIFO overflows and resume once it drains.
- Flags overflow and burst-protocol errors as sticky status bits.

Parameters:
- DATA_W, 16, width of one SDRAM word and of the output data.
- DEPTH, 64, FIFO entries; power of 2, >= 8.
- BURST_LEN, 2, words captured per burst; must match the controller mode register.
- HI_WM, 56, level at or above which reads are throttled; DEPTH-HI_WM >= 2*BURST_LEN.
- LO_WM, 16, level at or below which reads resume; LO_WM < HI_WM.

Ports:
- ck143  in  1  system clock, same clock as the SDRAM controller; all logic is on posedge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  synchronous flush; same clear as fed to the controller.
- burst_start  in  1  one-cycle pulse; the first burst word is on rd_dq this cycle.
- rd_dq  in  DATA_W  SDRAM read data (registered copy of mem_dq).
- pause  out  1  one-cycle pulse: request controller to stop issuing reads.
- unpause  out  1  one-cycle pulse: allow controller to resume.
- out_data  out  DATA_W  head-of-FIFO word.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word when out_valid && out_ready.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a captured word was dropped because the FIFO was full.
- protocol_err  out  1  sticky: burst_start arrived while a capture was in progress.

Behaviour:
- Reset (reset=1 at posedge): pointers=0, level=0, out_valid=0, out_data=0, pause=0, unpause=0, overflow=0, protocol_err=0, capture FSM=IDLE, throttle flag=0. No pulses are emitted by reset.
- clear (reset=0): same effect as reset, with one exception: if the throttle flag was 1, unpause pulses for 1 cycle on the next cycle. A capture in progress is aborted and its remaining words are not written.
- Capture FSM: IDLE and CAPTURE, with word counter cnt (0..BURST_LEN-1).
  - IDLE + burst_start: push rd_dq, set cnt=1, go to CAPTURE (stay in IDLE if BURST_LEN=1).
  - CAPTURE: push rd_dq every cycle and increment cnt; return to IDLE after the push where cnt==BURST_LEN-1.
  - burst_start in CAPTURE: ignored (the word is still captured as part of the current burst); set protocol_err.
- Push/pop rules:
  - Pop occurs when out_valid && out_ready.
  - Push while full and no pop in the same cycle: word dropped, overflow set, level unchanged.
  - Push and pop in the same cycle while full: both succeed, level unchanged.
  - Push and pop in the same cycle while empty: impossible, since out_valid=0; no bypass.
- Latency: a word pushed at edge N is visible on out_data/out_valid after edge N+1.
  - out_data is registered, first-word-fall-through style.
  - out_valid=1 iff level>0 after head load.
  - out_data holds stable while out_valid && !out_ready.
- level: updated every cycle by +push-pop (pushes that are dropped do not count). Pointers wrap mod DEPTH.
- Throttle:
  - When the updated level >= HI_WM and throttle flag=0: pause=1 for exactly one cycle, flag<=1.
  - When the updated level <= LO_WM and flag=1: unpause=1 for one cycle, flag<=0.
  - pause and unpause are never high in the same cycle.
  - No repeated pulses while the level stays beyond a watermark.
- Headroom guarantee: with one in-flight burst after pause, the FIFO never overflows given DEPTH-HI_WM >= 2*BURST_LEN.
- Sticky flags clear only on reset or clear.

Test Plan:
- Reset, then 3 bursts (0x1111,0x2222 / 0x3333,0x4444 / 0x5555,0x6666) with out_ready=1 -> out_data sequence 0x1111..0x6666 in order; first out_valid 2 cycles after the first burst_start; level returns to 0.
- out_ready=0; 28 bursts -> pause pulses exactly once on the cycle level reaches 56; no overflow.
- Then out_ready=1 -> unpause pulses exactly once when level drops to 16; no further pause/unpause pulses.
- out_ready=0; 33 bursts ignoring pause -> level=64, overflow=1 after the 65th word; the 65th and 66th words are dropped; draining yields exactly the first 64 words.
- burst_start pulses on two consecutive cycles -> protocol_err=1; 2 words are captured, not 3; level=2.
- After pause, assert clear mid-burst -> level=0, out_valid=0, unpause pulses on the next cycle, and the aborted burst's second word is not written.
